// File: rtl/req_encoder.sv
// req_encoder: registered N-to-W request encoder with valid/ready handshake (in: clk rst_n en clear req[N] ready; out: code[W] valid pending[N])
module req_encoder #(
  parameter int N = 8,
  parameter int W = 3,
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clear,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic [W-1:0] code,
  output logic         valid,
  output logic [N-1:0] pending
);
  logic [N-1:0] pending_q, pending_d, served, cand;
  logic [W-1:0] code_q, code_d, ptr_q, ptr_d, base, sel, idx;
  logic         valid_q, valid_d, accept, free, found;
  always_comb begin
    accept = valid_q && ready;
    served = accept ? N'(1) << code_q : '0;
    cand = pending_q & ~served;
    base = accept ? code_q : ptr_q;
    free = !valid_q || ready;
    sel = '0;
    found = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ROUND_ROBIN ? W'(base + W'(1) + W'(k)) : W'(k);
      if (cand[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
    pending_d = clear ? '0 : cand | (en ? req : '0);
    valid_d = clear ? 1'b0 : free ? found : valid_q;
    code_d = (!clear && free && found) ? sel : code_q;
    ptr_d = clear ? W'(N - 1) : base;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      valid_q <= 1'b0;
      code_q <= '0;
      ptr_q <= W'(N - 1);
    end else begin
      pending_q <= pending_d;
      valid_q <= valid_d;
      code_q <= code_d;
      ptr_q <= ptr_d;
    end
  end
  assign code = code_q;
  assign valid = valid_q;
  assign pending = pending_q;
endmodule

// File: tb/tb_req_encoder.sv
// tb_req_encoder: randomized scoreboard bench for fixed-priority and round-robin req_encoder
module tb_req_encoder;
  typedef struct {
    bit [7:0] pend;
    bit       v;
    int       code;
    int       ptr;
  } mst_t;
  logic       clk = 1'b0;
  logic       rst_n, en, clear, ready;
  logic [7:0] req;
  logic [2:0] d_code [2];
  logic       d_valid [2];
  logic [7:0] d_pend [2];
  mst_t       ms [2];
  int         q [2][$];
  int         n_cmp = 0;
  int         n_err = 0;
  mst_t       nx;
  bit         pushed;
  always #5 clk = ~clk;
  req_encoder #(.N(8), .W(3), .ROUND_ROBIN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .req(req), .ready(ready),
    .code(d_code[0]), .valid(d_valid[0]), .pending(d_pend[0]));
  req_encoder #(.N(8), .W(3), .ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .req(req), .ready(ready),
    .code(d_code[1]), .valid(d_valid[1]), .pending(d_pend[1]));
  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask
  // One clock of the request/grant rules: an accepted grant leaves the pending
  // set, new requests join it, and a free output slot takes the next winner.
  function automatic mst_t step(input mst_t s, input bit rr, input bit e, input bit clr,
                                input bit [7:0] r, input bit rdy, output bit push);
    mst_t n = s;
    bit [7:0] avail;
    int idx;
    push = 1'b0;
    if (clr) begin
      n.pend = 8'h00;
      n.v = 1'b0;
      n.ptr = 7;
      return n;
    end
    if (s.v && rdy) begin
      n.pend[s.code] = 1'b0;
      n.ptr = s.code;
    end
    avail = n.pend;
    if (e) n.pend = n.pend | r;
    if (!s.v || rdy) begin
      n.v = 1'b0;
      for (int k = 0; k < 8; k++) begin
        idx = rr ? (n.ptr + 1 + k) % 8 : k;
        if (avail[idx]) begin
          n.v = 1'b1;
          n.code = idx;
          push = 1'b1;
          break;
        end
      end
    end
    return n;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        ms[i] = '{pend: 8'h00, v: 1'b0, code: 0, ptr: 7};
        q[i].delete();
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        nx = step(ms[i], i == 1, en, clear, req, ready, pushed);
        if (clear && ms[i].v && !ready && q[i].size() > 0) void'(q[i].pop_back());
        if (pushed) q[i].push_back(nx.code);
        ms[i] = nx;
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk("valid", i, int'(d_valid[i]), int'(ms[i].v));
        chk("pending", i, int'(d_pend[i]), int'(ms[i].pend));
        if (d_valid[i] && ready) begin
          if (q[i].size() == 0) chk("code_unexpected", i, int'(d_code[i]), -1);
          else chk("code", i, int'(d_code[i]), q[i].pop_front());
        end
      end
    end
  end
  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    clear = 1'b0;
    req = 8'h00;
    ready = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_valid", i, int'(d_valid[i]), 0);
      chk("reset_code", i, int'(d_code[i]), 0);
      chk("reset_pending", i, int'(d_pend[i]), 0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int ph = 0; ph < 5; ph++) begin
      for (int c = 0; c < 300; c++) begin
        @(posedge clk);
        #1;
        case (ph)
          0: begin
            en = 1'b1;
            clear = 1'b0;
            req = ($urandom % 4 == 0) ? 8'(1 << ($urandom % 8)) : 8'h00;
            ready = ($urandom % 4 != 0);
          end
          1: begin
            en = ($urandom % 2 == 0);
            clear = ($urandom % 40 == 0);
            req = 8'($urandom);
            ready = ($urandom % 3 == 0);
          end
          2: begin
            en = 1'b0;
            clear = ($urandom % 50 == 0);
            req = 8'hFF;
            ready = ($urandom % 2 == 0);
          end
          3: begin
            en = 1'b1;
            clear = 1'b0;
            req = 8'h03;
            ready = 1'b1;
          end
          default: begin
            en = ($urandom % 4 != 0);
            clear = ($urandom % 30 == 0);
            req = ($urandom % 2 == 0) ? 8'($urandom) : 8'h00;
            ready = ($urandom % 2 == 0);
            if ($urandom % 60 == 0) begin
              rst_n = 1'b0;
              #1;
              for (int i = 0; i < 2; i++) begin
                chk("async_rst_valid", i, int'(d_valid[i]), 0);
                chk("async_rst_code", i, int'(d_code[i]), 0);
                chk("async_rst_pending", i, int'(d_pend[i]), 0);
              end
              @(posedge clk);
              #1 rst_n = 1'b1;
            end
          end
        endcase
      end
    end
    @(posedge clk);
    #1;
    en = 1'b0;
    clear = 1'b0;
    req = 8'h00;
    ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("drain_queue", i, q[i].size(), 0);
      chk("drain_valid", i, int'(d_valid[i]), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
